// File: rtl/seq_mini_alu.sv
// Registered add/subtract/shift unit with valid/ready handshakes on both sides.
// Shifts run one bit per cycle; the result and its status flags are registered together.
module seq_mini_alu #(
    parameter int WIDTH = 4,
    parameter int RES_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             operation,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    localparam int CW = $clog2(RES_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] acc_sh;
    logic [RES_W-1:0] arith;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    k;
    logic             dir_right;
    logic             ovf_acc;
    logic             ovf_acc_nx;
    logic             accept;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CW'(1));

    always_comb begin
        k          = CW'(op2);
        if (32'(op2) > 32'(RES_W)) begin
            k = CW'(RES_W);
        end
        arith      = sign ? (RES_W'(op1) - RES_W'(op2)) : (RES_W'(op1) + RES_W'(op2));
        acc_sh     = dir_right ? (acc >> 1) : (acc << 1);
        ovf_acc_nx = ovf_acc | (!dir_right && acc[RES_W-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (operation && k != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The accumulator shifts privately; result/flags only change when an operation completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            dir_right <= 1'b0;
            ovf_acc   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!operation) begin
                            result <= arith;
                            zero   <= (arith == '0);
                            neg    <= sign && (op1 < op2);
                            ovf    <= 1'b0;
                        end else begin
                            acc       <= RES_W'(op1);
                            cnt       <= k;
                            dir_right <= sign;
                            ovf_acc   <= 1'b0;
                            if (k == '0) begin
                                result <= RES_W'(op1);
                                zero   <= (op1 == '0);
                                neg    <= 1'b0;
                                ovf    <= 1'b0;
                            end
                        end
                    end
                end
                SHIFT: begin
                    acc     <= acc_sh;
                    cnt     <= cnt - CW'(1);
                    ovf_acc <= ovf_acc_nx;
                    if (last) begin
                        result <= acc_sh;
                        zero   <= (acc_sh == '0);
                        neg    <= 1'b0;
                        ovf    <= ovf_acc_nx;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mini_alu.sv
// Randomized and directed checks of seq_mini_alu (RES_W=20 and RES_W=8 builds)
// against an arithmetic reference model.
module tb_seq_mini_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  op1, op2;
    logic        operation, sign, out_ready;
    logic        iv20, iv8;
    logic        ir20, ov20, z20, n20, o20;
    logic        ir8, ov8, z8, n8, o8;
    logic [19:0] r20;
    logic [7:0]  r8;
    logic        sel8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_mini_alu #(.WIDTH(4), .RES_W(20)) dut20 (
        .clk(clk), .rst(rst), .in_valid(iv20), .in_ready(ir20),
        .op1(op1), .op2(op2), .operation(operation), .sign(sign),
        .out_valid(ov20), .out_ready(out_ready), .result(r20),
        .zero(z20), .neg(n20), .ovf(o20)
    );

    seq_mini_alu #(.WIDTH(4), .RES_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .op1(op1), .op2(op2), .operation(operation), .sign(sign),
        .out_valid(ov8), .out_ready(out_ready), .result(r8),
        .zero(z8), .neg(n8), .ovf(o8)
    );

    wire        obs_ready = sel8 ? ir8 : ir20;
    wire        obs_valid = sel8 ? ov8 : ov20;
    wire [19:0] obs_res   = sel8 ? {12'd0, r8} : r20;
    wire        obs_zero  = sel8 ? z8 : z20;
    wire        obs_neg   = sel8 ? n8 : n20;
    wire        obs_ovf   = sel8 ? o8 : o20;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_model(input int rw, input int a, input int b, input bit opn,
                                      input bit sg, output longint unsigned r, output bit z,
                                      output bit n, output bit o, output int lat);
        longint unsigned mask, full;
        int k;
        mask = (64'd1 << rw) - 64'd1;
        n    = 1'b0;
        o    = 1'b0;
        lat  = 1;
        if (!opn) begin
            full = sg ? (longint'(a) - longint'(b)) : (longint'(a) + longint'(b));
            r    = full & mask;
            n    = sg && (a < b);
        end else begin
            k   = (b > rw) ? rw : b;
            lat = 1 + k;
            if (sg) begin
                r = longint'(a) >> k;
            end else begin
                full = longint'(a) << k;
                r    = full & mask;
                o    = (full >> rw) != 0;
            end
        end
        z = (r == 0);
    endfunction

    task automatic run_op(input bit b8, input int a, input int b, input bit opn, input bit sg,
                          input int hold);
        longint unsigned er;
        bit ez, en, eo;
        int lat, cyc;
        ref_model(b8 ? 8 : 20, a, b, opn, sg, er, ez, en, eo, lat);
        sel8 = b8;
        @(negedge clk);
        check("in_ready_idle", obs_ready, 1);
        op1       = 4'(a);
        op2       = 4'(b);
        operation = opn;
        sign      = sg;
        out_ready = (hold == 0);
        if (b8) iv8 = 1'b1; else iv20 = 1'b1;
        @(negedge clk);
        iv8       = 1'b0;
        iv20      = 1'b0;
        op1       = 4'($urandom);
        op2       = 4'($urandom);
        operation = 1'($urandom);
        sign      = 1'($urandom);
        cyc = 1;
        while (!obs_valid && cyc < 200) begin
            check("in_ready_busy", obs_ready, 0);
            @(negedge clk);
            cyc++;
        end
        check("latency", longint'(cyc), longint'(lat));
        check("result", obs_res, er);
        check("zero", obs_zero, ez);
        check("neg", obs_neg, en);
        check("ovf", obs_ovf, eo);
        check("in_ready_done", obs_ready, 0);
        for (int h = 0; h < hold; h++) begin
            if (b8) iv8 = 1'b1; else iv20 = 1'b1;
            op1 = 4'($urandom);
            op2 = 4'($urandom);
            @(negedge clk);
            check("hold_valid", obs_valid, 1);
            check("hold_ready", obs_ready, 0);
            check("hold_result", obs_res, er);
            check("hold_neg", obs_neg, en);
        end
        iv8       = 1'b0;
        iv20      = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", obs_valid, 0);
        check("release_ready", obs_ready, 1);
    endtask

    initial begin
        rst = 1'b1; iv20 = 1'b0; iv8 = 1'b0; out_ready = 1'b1; sel8 = 1'b0;
        op1 = '0; op2 = '0; operation = 1'b0; sign = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready20", ir20, 1);
        check("rst_valid20", ov20, 0);
        check("rst_result20", r20, 0);
        check("rst_flags20", {z20, n20, o20}, 0);
        check("rst_ready8", ir8, 1);
        check("rst_valid8", ov8, 0);
        check("rst_result8", r8, 0);

        run_op(0, 10, 10, 0, 0, 0);   // add -> 20
        run_op(0, 10, 11, 0, 1, 0);   // sub -> FFFFF, neg
        run_op(0, 10, 10, 0, 1, 0);   // sub -> 0, zero
        run_op(0, 10, 10, 1, 0, 0);   // shl 10 -> 0x2800
        run_op(0, 10, 0, 1, 0, 0);    // shl 0 -> 10
        run_op(0, 10, 1, 1, 1, 0);    // shr 1 -> 5
        run_op(1, 10, 6, 1, 0, 0);    // 8-bit shl -> 0x80, ovf
        run_op(1, 15, 15, 1, 0, 0);   // 8-bit saturating shl -> 0, ovf
        run_op(0, 3, 7, 0, 1, 5);     // backpressure on FFFFC

        for (int i = 0; i < 40; i++)
            run_op(0, int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom),
                   1'($urandom), int'($urandom_range(3)));
        for (int i = 0; i < 20; i++)
            run_op(1, int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom),
                   1'($urandom), int'($urandom_range(3)));

        run_op(0, 10, 10, 0, 0, 0);
        sel8 = 1'b0;
        @(negedge clk);
        op1 = 4'd1; op2 = 4'd12; operation = 1'b1; sign = 1'b0; iv20 = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        iv20 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", ov20, 0);
        check("midrst_result", r20, 0);
        check("midrst_ready", ir20, 1);
        check("midrst_flags", {z20, n20, o20}, 0);
        run_op(0, 3, 4, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_mini_alu.md
Name: seq_mini_alu

Overview:
- Registered, parametrised successor to the team's combinational mini ALU.
- Same four operations: add, subtract, shift-left and shift-right, encoded with the existing {operation, sign} pair.
- Adds a valid/ready handshake on both sides, an iterative one-bit-per-cycle shifter, and zero/negative/overflow status flags.
- Sits between the operand input logic and the result display/formatting stage.

Parameters:
- WIDTH, 4: operand width in bits.
- RES_W, 20: result width in bits. Must satisfy RES_W >= WIDTH+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  block can accept an operation.
- op1  input  WIDTH  first operand, unsigned.
- op2  input  WIDTH  second operand, unsigned; this is the shift count for shift operations.
- operation  input  1  0 = arithmetic, 1 = shift.
- sign  input  1  arithmetic: 0 = add, 1 = subtract. Shift: 0 = left, 1 = right (logical).
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  RES_W  result value.
- zero  output  1  result == 0.
- neg  output  1  subtract result negative (op1 < op2).
- ovf  output  1  shift-left lost a 1 bit beyond RES_W.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; result, zero, neg, ovf, out_valid all 0; in_ready 1 in the first cycle after reset.
  - Reset wins over every other event, including mid-shift and a pending result; the in-flight operation is discarded.
- States: IDLE, SHIFT, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- Accept occurs when in_valid && in_ready at a clock edge (cycle N).
  - Opcode and operands are captured at accept; input changes after that are ignored.
- Add: result = zero-extended op1 + op2; neg = 0; ovf = 0. Next state DONE, so out_valid is high in cycle N+1.
- Subtract: result = op1 - op2 as two's complement, sign-extended to RES_W; neg = (op1 < op2); ovf = 0. Next state DONE.
- Shift: let k = min(op2, RES_W).
  - Accumulator is loaded with zero-extended op1; counter = k.
  - If k == 0: DONE next cycle with result = op1.
  - Otherwise go to SHIFT. Each SHIFT cycle shifts the accumulator one bit (left or right, zero fill) and decrements the counter.
  - Left shift sets the sticky ovf if the bit shifted out of the MSB is 1.
  - When the counter reaches 0 after a shift, go to DONE.
  - out_valid first asserts in cycle N+1+k.
  - Shift counts >= RES_W saturate at RES_W iterations, giving result 0. ovf = 1 if op1 != 0 for left shifts.
- zero is computed from the final result and is registered with it.
- DONE: result and flags stay stable until out_valid && out_ready, then return to IDLE.
  - in_ready stays 0 throughout SHIFT and DONE, so there is no bypass.
  - Maximum throughput is one operation per 2 cycles.
- In IDLE, result and flags hold their last values; only out_valid qualifies them.
- In_valid while in_ready = 0 is ignored; the source must hold its request until accepted.

Test Plan:
- Add, defaults: op1=10, op2=10, add. -> out_valid at N+1, result=20, zero=0, neg=0, ovf=0.
- Subtract: op1=10, op2=11. -> result=20'hFFFFF, neg=1. Then op1=10, op2=10 subtract. -> result=0, zero=1, neg=0.
- Shift-left latency: op1=10, op2=10, shift-left. -> in_ready low cycles N+1..N+11, out_valid at N+11, result=10240 (20'h02800), ovf=0. Same with op2=0. -> out_valid at N+1, result=10.
- Shift-right / overflow:
  - op1=10, op2=1, shift-right. -> result=5 at N+2.
  - RES_W=8 build: op1=10, op2=6, shift-left. -> result=8'h80, ovf=1.
  - RES_W=8 build: op1=15, op2=15, shift-left. -> 8 iterations, result=0, zero=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after a subtract of 3-7. -> result=20'hFFFFC and neg=1 held stable, in_ready=0, a new in_valid is ignored. Releasing out_ready returns to IDLE in the next cycle.
- Reset mid-operation: start shift-left op1=1, op2=12 and assert rst in the 4th SHIFT cycle. -> next cycle: out_valid=0, result=0, in_ready=1. A following add 3+4 gives result=7 at N+1.
